// File: rtl/step_phase_decoder_pkg.sv
// Shared definitions for the step phase decoder.
// Holds the unipolar half-step pattern table, the phase index width,
// the lock FSM state type and the pattern classification helper.
// No ports (package).
package step_phase_pkg;

  localparam int IDX_W      = 3;
  localparam int NUM_PHASES = 8;

  // Half-step sequence in forward order; the array position is the phase index.
  localparam logic [3:0] HALF_STEP_TABLE [NUM_PHASES] = '{
    4'b0001, 4'b0011, 4'b0010, 4'b0110,
    4'b0100, 4'b1100, 4'b1000, 4'b1001
  };

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  typedef struct packed {
    logic             legal;
    logic             idle;
    logic [IDX_W-1:0] index;
  } pat_info_t;

  // Classifies a coil pattern: legal half-step position, coils-off idle,
  // or neither (illegal). Index is only meaningful when legal is set.
  function automatic pat_info_t pattern_to_index(input logic [3:0] pat);
    pat_info_t info;
    info.legal = 1'b0;
    info.idle  = (pat == 4'b0000);
    info.index = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (pat == HALF_STEP_TABLE[i]) begin
        info.legal = 1'b1;
        info.index = IDX_W'(i);
      end
    end
    return info;
  endfunction

endpackage

// File: rtl/step_phase_decoder_phase_filter.sv
// phase_filter: brings the asynchronous coil lines into the clock domain
// with a 2-FF synchronizer, then accepts a pattern only after it has been
// stable for FILTER_CYCLES consecutive cycles.
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous active-low reset
//   i_phase      raw coil phase lines
//   o_pattern    last accepted (debounced) pattern
//   o_newPattern one-cycle strobe each time a pattern is accepted
module phase_filter #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_phase,
  output logic [3:0] o_pattern,
  output logic       o_newPattern
);

  localparam logic [7:0] F_CNT = 8'(FILTER_CYCLES);

  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] r_cand;
  logic [7:0] r_cnt;
  logic [3:0] r_pattern;
  logic       r_newPattern;

  // The counter holds how many consecutive cycles r_cand has matched the
  // synchronized input. A pattern is accepted on the cycle the count reaches
  // FILTER_CYCLES; the count then parks there so acceptance fires only once
  // per stable run. A one-cycle filter accepts on the candidate load itself.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync1      <= 4'b0000;
      r_sync2      <= 4'b0000;
      r_cand       <= 4'b0000;
      r_cnt        <= 8'd0;
      r_pattern    <= 4'b0000;
      r_newPattern <= 1'b0;
    end else begin
      r_sync1      <= i_phase;
      r_sync2      <= r_sync1;
      r_newPattern <= 1'b0;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= 8'd1;
        if (F_CNT == 8'd1) begin
          r_pattern    <= r_sync2;
          r_newPattern <= 1'b1;
        end
      end else if (r_cnt < F_CNT) begin
        r_cnt <= r_cnt + 8'd1;
        if (r_cnt + 8'd1 == F_CNT) begin
          r_pattern    <= r_cand;
          r_newPattern <= 1'b1;
        end
      end
    end
  end

  assign o_pattern    = r_pattern;
  assign o_newPattern = r_newPattern;

endmodule

// File: rtl/step_phase_decoder.sv
// step_phase_decoder: decodes step events, direction and accumulated
// half-step position from the four unipolar coil phase lines, flags illegal
// patterns and missed steps, and measures the step period in clock cycles.
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   phase_in     coil phase lines (asynchronous)
//   clr          synchronous clear of position, fault and period measurement
//   position     signed half-step position (wraps)
//   dir          direction of last step, 1 = forward
//   step_pulse   one-cycle pulse per accepted step
//   locked       a valid reference phase index is held
//   fault        sticky illegal-pattern / missed-step flag
//   period       clock cycles between the last two steps
//   period_valid period holds a real step-to-step measurement
module step_phase_decoder
  import step_phase_pkg::*;
#(
  parameter int FILTER_CYCLES = 4,
  parameter int POS_W         = 16,
  parameter int PER_W         = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              phase_in,
  input  logic                    clr,
  output logic signed [POS_W-1:0] position,
  output logic                    dir,
  output logic                    step_pulse,
  output logic                    locked,
  output logic                    fault,
  output logic [PER_W-1:0]        period,
  output logic                    period_valid
);

  logic [3:0]       w_pattern;
  logic             w_newPattern;

  state_t           r_state,      w_stateNext;
  logic [IDX_W-1:0] r_index,      w_indexNext;
  logic [POS_W-1:0] r_position,   w_positionNext;
  logic             r_dir,        w_dirNext;
  logic             r_stepPulse,  w_stepPulseNext;
  logic             r_fault,      w_faultNext;
  logic [PER_W-1:0] r_periodCnt,  w_periodCntNext;
  logic [PER_W-1:0] r_period,     w_periodNext;
  logic             r_periodValid, w_periodValidNext;
  logic             r_stepSeen,   w_stepSeenNext;
  logic [PER_W-1:0] w_cntInc;
  logic [IDX_W-1:0] w_diff;
  pat_info_t        w_info;

  phase_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_phase     (phase_in),
    .o_pattern   (w_pattern),
    .o_newPattern(w_newPattern)
  );

  // Saturating increment, shared by the free-running counter and the
  // captured period (captured value is counter+1 so it counts the step cycle).
  assign w_cntInc = (r_periodCnt == '1) ? r_periodCnt : r_periodCnt + PER_W'(1);

  // Next-state logic. The 3-bit index difference wraps modulo 8, so a
  // reverse half step shows up as 7 and a reverse full step as 6.
  // r_stepSeen remembers the first step since locking so period_valid only
  // rises once a true step-to-step interval has been captured.
  // clr is applied last so it overrides position and fault, while dir and
  // step_pulse still reflect a coincident step.
  always_comb begin
    w_stateNext       = r_state;
    w_indexNext       = r_index;
    w_positionNext    = r_position;
    w_dirNext         = r_dir;
    w_stepPulseNext   = 1'b0;
    w_faultNext       = r_fault;
    w_periodCntNext   = w_cntInc;
    w_periodNext      = r_period;
    w_periodValidNext = r_periodValid;
    w_stepSeenNext    = r_stepSeen;
    w_info            = pattern_to_index(w_pattern);
    w_diff            = w_info.index - r_index;

    if (w_newPattern && !w_info.idle) begin
      if (!w_info.legal) begin
        w_faultNext = 1'b1;
        w_stateNext = UNLOCKED;
      end else begin
        w_indexNext = w_info.index;
        if (r_state == UNLOCKED) begin
          w_stateNext = LOCKED;
        end else begin
          case (w_diff)
            3'd0: begin
              w_stateNext = LOCKED;
            end
            3'd1: begin
              w_positionNext  = r_position + POS_W'(1);
              w_dirNext       = 1'b1;
              w_stepPulseNext = 1'b1;
            end
            3'd2: begin
              w_positionNext  = r_position + POS_W'(2);
              w_dirNext       = 1'b1;
              w_stepPulseNext = 1'b1;
            end
            3'd7: begin
              w_positionNext  = r_position - POS_W'(1);
              w_dirNext       = 1'b0;
              w_stepPulseNext = 1'b1;
            end
            3'd6: begin
              w_positionNext  = r_position - POS_W'(2);
              w_dirNext       = 1'b0;
              w_stepPulseNext = 1'b1;
            end
            default: begin
              w_faultNext = 1'b1;
              w_stateNext = UNLOCKED;
            end
          endcase
        end
      end
    end

    if (w_stepPulseNext) begin
      w_periodNext    = w_cntInc;
      w_periodCntNext = '0;
      if (r_stepSeen) begin
        w_periodValidNext = 1'b1;
      end else begin
        w_stepSeenNext = 1'b1;
      end
    end

    if (w_stateNext == UNLOCKED) begin
      w_periodValidNext = 1'b0;
      w_stepSeenNext    = 1'b0;
    end

    if (clr) begin
      w_positionNext    = '0;
      w_faultNext       = 1'b0;
      w_periodValidNext = 1'b0;
      w_stepSeenNext    = 1'b0;
      w_periodCntNext   = '0;
    end
  end

  // State register for the lock FSM and all decoder outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= UNLOCKED;
      r_index       <= '0;
      r_position    <= '0;
      r_dir         <= 1'b0;
      r_stepPulse   <= 1'b0;
      r_fault       <= 1'b0;
      r_periodCnt   <= '0;
      r_period      <= '0;
      r_periodValid <= 1'b0;
      r_stepSeen    <= 1'b0;
    end else begin
      r_state       <= w_stateNext;
      r_index       <= w_indexNext;
      r_position    <= w_positionNext;
      r_dir         <= w_dirNext;
      r_stepPulse   <= w_stepPulseNext;
      r_fault       <= w_faultNext;
      r_periodCnt   <= w_periodCntNext;
      r_period      <= w_periodNext;
      r_periodValid <= w_periodValidNext;
      r_stepSeen    <= w_stepSeenNext;
    end
  end

  assign position     = r_position;
  assign dir          = r_dir;
  assign step_pulse   = r_stepPulse;
  assign locked       = (r_state == LOCKED);
  assign fault        = r_fault;
  assign period       = r_period;
  assign period_valid = r_periodValid;

endmodule

// File: tb/tb_step_phase_decoder.sv
// Testbench for step_phase_decoder with default parameters
// (FILTER_CYCLES=4, POS_W=16, PER_W=24). Directed scenarios, each task
// drives stimulus on the falling edge and checks outputs on falling edges.
module tb_step_phase_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  phase_in;
  logic        clr;
  logic [15:0] position;
  logic        dir;
  logic        step_pulse;
  logic        locked;
  logic        fault;
  logic [23:0] period;
  logic        period_valid;

  int errors = 0;
  int checks = 0;

  step_phase_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .phase_in    (phase_in),
    .clr         (clr),
    .position    (position),
    .dir         (dir),
    .step_pulse  (step_pulse),
    .locked      (locked),
    .fault       (fault),
    .period      (period),
    .period_valid(period_valid)
  );

  always #5 clk = ~clk;

  // Drives a pattern for a number of cycles, counting step pulses seen.
  task automatic drive_hold(input logic [3:0] pat, input int cycles, output int pulses);
    phase_in = pat;
    pulses   = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (step_pulse === 1'b1) pulses++;
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; clr = 1'b0; phase_in = 4'b0000;
    repeat (2) @(negedge clk);
    checks++; if (position !== 16'h0000) begin errors++; $display("[TB] FAIL reset_position: got %h expected 0000", position); end
    checks++; if (dir !== 1'b0) begin errors++; $display("[TB] FAIL reset_dir: got %b expected 0", dir); end
    checks++; if (step_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_step_pulse: got %b expected 0", step_pulse); end
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %b expected 0", locked); end
    checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault: got %b expected 0", fault); end
    checks++; if (period !== 24'h0) begin errors++; $display("[TB] FAIL reset_period: got %h expected 0", period); end
    checks++; if (period_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_period_valid: got %b expected 0", period_valid); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_forward();
    logic [3:0] seq [8] = '{4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000, 4'b1001, 4'b0001};
    int p;
    int total = 0;
    drive_hold(4'b0001, 20, p);
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL fwd_lock: got %b expected 1", locked); end
    checks++; if (p !== 0) begin errors++; $display("[TB] FAIL fwd_lock_pulses: got %0d expected 0", p); end
    checks++; if (position !== 16'h0000) begin errors++; $display("[TB] FAIL fwd_lock_position: got %h expected 0000", position); end
    for (int i = 0; i < 8; i++) begin
      drive_hold(seq[i], 20, p);
      total += p;
      if (i == 0) begin
        checks++; if (period_valid !== 1'b0) begin errors++; $display("[TB] FAIL fwd_valid_first: got %b expected 0", period_valid); end
      end
      if (i == 1) begin
        checks++; if (period_valid !== 1'b1) begin errors++; $display("[TB] FAIL fwd_valid_second: got %b expected 1", period_valid); end
        checks++; if (period !== 24'd20) begin errors++; $display("[TB] FAIL fwd_period_second: got %0d expected 20", period); end
      end
    end
    checks++; if (total !== 8) begin errors++; $display("[TB] FAIL fwd_pulses: got %0d expected 8", total); end
    checks++; if (dir !== 1'b1) begin errors++; $display("[TB] FAIL fwd_dir: got %b expected 1", dir); end
    checks++; if (position !== 16'h0008) begin errors++; $display("[TB] FAIL fwd_position: got %h expected 0008", position); end
    checks++; if (period !== 24'd20) begin errors++; $display("[TB] FAIL fwd_period: got %0d expected 20", period); end
    checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL fwd_fault: got %b expected 0", fault); end
  endtask

  task automatic test_reverse();
    int p;
    int total = 0;
    pulse_clr();
    checks++; if (position !== 16'h0000) begin errors++; $display("[TB] FAIL clr_position: got %h expected 0000", position); end
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL clr_keeps_lock: got %b expected 1", locked); end
    checks++; if (period_valid !== 1'b0) begin errors++; $display("[TB] FAIL clr_valid: got %b expected 0", period_valid); end
    drive_hold(4'b1001, 20, p); total += p;
    drive_hold(4'b1000, 20, p); total += p;
    drive_hold(4'b1100, 20, p); total += p;
    checks++; if (position !== 16'hFFFD) begin errors++; $display("[TB] FAIL rev_position: got %h expected FFFD", position); end
    checks++; if (dir !== 1'b0) begin errors++; $display("[TB] FAIL rev_dir: got %b expected 0", dir); end
    checks++; if (total !== 3) begin errors++; $display("[TB] FAIL rev_pulses: got %0d expected 3", total); end
  endtask

  task automatic test_full_step();
    int p;
    int total = 0;
    // From index 5: full step to 7, half step to 0, then re-zero.
    drive_hold(4'b1001, 20, p);
    drive_hold(4'b0001, 20, p);
    pulse_clr();
    drive_hold(4'b0010, 20, p); total += p;
    drive_hold(4'b0100, 20, p); total += p;
    checks++; if (position !== 16'h0004) begin errors++; $display("[TB] FAIL full_position: got %h expected 0004", position); end
    checks++; if (total !== 2) begin errors++; $display("[TB] FAIL full_pulses: got %0d expected 2", total); end
    checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL full_fault: got %b expected 0", fault); end
    checks++; if (dir !== 1'b1) begin errors++; $display("[TB] FAIL full_dir: got %b expected 1", dir); end
  endtask

  task automatic test_glitch_latency();
    int p;
    int total = 0;
    int lat = 0;
    drive_hold(4'b0110, 2, p); total += p;
    drive_hold(4'b0100, 20, p); total += p;
    checks++; if (total !== 0) begin errors++; $display("[TB] FAIL glitch_pulses: got %0d expected 0", total); end
    checks++; if (position !== 16'h0004) begin errors++; $display("[TB] FAIL glitch_position: got %h expected 0004", position); end
    phase_in = 4'b1100;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (step_pulse === 1'b1 && lat == 0) lat = n;
    end
    checks++; if (lat !== 7) begin errors++; $display("[TB] FAIL latency: got %0d expected 7 edges", lat); end
    checks++; if (position !== 16'h0005) begin errors++; $display("[TB] FAIL latency_position: got %h expected 0005", position); end
  endtask

  task automatic test_faults();
    int p;
    drive_hold(4'b0101, 20, p);
    checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL illegal_fault: got %b expected 1", fault); end
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL illegal_locked: got %b expected 0", locked); end
    checks++; if (position !== 16'h0005) begin errors++; $display("[TB] FAIL illegal_position: got %h expected 0005", position); end
    checks++; if (period_valid !== 1'b0) begin errors++; $display("[TB] FAIL illegal_valid: got %b expected 0", period_valid); end
    drive_hold(4'b0001, 20, p);
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL relock: got %b expected 1", locked); end
    checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL fault_sticky: got %b expected 1", fault); end
    drive_hold(4'b0110, 20, p);
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL skip_locked: got %b expected 0", locked); end
    checks++; if (p !== 0) begin errors++; $display("[TB] FAIL skip_pulses: got %0d expected 0", p); end
    checks++; if (position !== 16'h0005) begin errors++; $display("[TB] FAIL skip_position: got %h expected 0005", position); end
    pulse_clr();
    checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL clr_fault: got %b expected 0", fault); end
    checks++; if (position !== 16'h0000) begin errors++; $display("[TB] FAIL clr_fault_position: got %h expected 0000", position); end
    drive_hold(4'b0011, 20, p);
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL relock2: got %b expected 1", locked); end
  endtask

  task automatic test_wrap();
    logic [3:0] tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000, 4'b1001};
    int p;
    drive_hold(4'b0001, 20, p);
    pulse_clr();
    // Full steps at the fastest rate the filter accepts: 16383 x +2 = 0x7FFE.
    for (int i = 1; i <= 16383; i++) begin
      drive_hold(tbl[(2 * i) % 8], 4, p);
    end
    drive_hold(4'b1001, 20, p);
    checks++; if (position !== 16'h7FFF) begin errors++; $display("[TB] FAIL wrap_preload: got %h expected 7FFF", position); end
    checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL wrap_fault: got %b expected 0", fault); end
    drive_hold(4'b0001, 20, p);
    checks++; if (position !== 16'h8000) begin errors++; $display("[TB] FAIL wrap_position: got %h expected 8000", position); end
    checks++; if (dir !== 1'b1) begin errors++; $display("[TB] FAIL wrap_dir: got %b expected 1", dir); end
  endtask

  task automatic test_async_reset();
    int p;
    phase_in = 4'b0011;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (position !== 16'h0000) begin errors++; $display("[TB] FAIL async_position: got %h expected 0000", position); end
    checks++; if (dir !== 1'b0) begin errors++; $display("[TB] FAIL async_dir: got %b expected 0", dir); end
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL async_locked: got %b expected 0", locked); end
    checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL async_fault: got %b expected 0", fault); end
    checks++; if (period !== 24'h0) begin errors++; $display("[TB] FAIL async_period: got %h expected 0", period); end
    checks++; if (period_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_valid: got %b expected 0", period_valid); end
    checks++; if (step_pulse !== 1'b0) begin errors++; $display("[TB] FAIL async_step_pulse: got %b expected 0", step_pulse); end
    @(negedge clk);
    rst = 1'b1;
    drive_hold(4'b0010, 20, p);
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL resume_locked: got %b expected 1", locked); end
    checks++; if (p !== 0) begin errors++; $display("[TB] FAIL resume_pulses: got %0d expected 0", p); end
    checks++; if (position !== 16'h0000) begin errors++; $display("[TB] FAIL resume_position: got %h expected 0000", position); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_full_step();
    test_glitch_latency();
    test_faults();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/step_phase_decoder.md
Name: step_phase_decoder

Overview:
- Receive-side counterpart to the unipolar 4-coil half-step driver. Monitors the 4 coil phase lines and decodes step events, direction and accumulated position.
- Sits between the phase pins (or a looped-back driver output) and the position/speed readout logic.
- Detects illegal patterns and skipped steps. Measures the step period in clock cycles.

Parameters:
- FILTER_CYCLES, 4: consecutive cycles a synchronized pattern must be stable before it is accepted; legal range 1..255.
- POS_W, 16: width of the signed position counter.
- PER_W, 24: width of the step-period counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- phase_in  in  4  coil phase lines, asynchronous to clk
- clr  in  1  synchronous clear of position/fault/period
- position  out  POS_W  signed half-step position, two's complement
- dir  out  1  direction of last step: 1 = forward (index +), 0 = reverse
- step_pulse  out  1  one-cycle pulse per accepted step event
- locked  out  1  decoder holds a valid reference phase index
- fault  out  1  sticky error flag
- period  out  PER_W  clk cycles between the last two step events
- period_valid  out  1  period holds a real measurement

Behaviour:
- Reset values: position=0, dir=0, step_pulse=0, locked=0, fault=0, period=0, period_valid=0. Synchronizer and filter are cleared to 4'b0000.
- Synchronizer: 2-FF on phase_in.
- Filter: the candidate pattern is accepted when it equals the synchronized value for FILTER_CYCLES consecutive cycles. Any change restarts the count.
- Half-step index table (pattern -> index): 0001->0, 0011->1, 0010->2, 0110->3, 0100->4, 1100->5, 1000->6, 1001->7.
- 0000 = coils off: no step, no fault, index and lock retained.
- Any other pattern is illegal.
- Latency: a clean change first present at phase_in on edge k produces step_pulse high in the cycle after edge k+FILTER_CYCLES+2. Total latency is FILTER_CYCLES+3 edges, i.e. 7 for the default.
- FSM states: UNLOCKED, LOCKED.
- UNLOCKED:
  - Legal accepted pattern -> store index, go LOCKED. No step, no position change.
  - Illegal pattern -> fault=1, stay.
- LOCKED, on each newly accepted legal pattern, compute d=(new-old) mod 8:
  - d=0: nothing.
  - d=1: position+1, dir=1, step_pulse.
  - d=7: position-1, dir=0, step_pulse.
  - d=2: position+2, dir=1, step_pulse (full-step drive).
  - d=6: position-2, dir=0, step_pulse.
  - d=3, 4 or 5: missed step. fault=1, go UNLOCKED, position unchanged.
- LOCKED, illegal pattern: fault=1, go UNLOCKED.
- Index register always updates to the new legal index.
- Position wraps in two's complement (0x7FFF+1 -> 0x8000). No saturation.
- Period measurement:
  - Counter increments every cycle and saturates at all-ones.
  - On a step event, period <= counter+1 (saturating), then counter <= 0.
  - period_valid=1 from the second step event after entering LOCKED.
  - Leaving LOCKED clears period_valid.
- clr (one cycle):
  - Sets position=0, fault=0, period_valid=0, period counter=0.
  - Lock state and stored index are unchanged.
  - If a step occurs in the same cycle, clr wins for position (ends at 0), while dir and step_pulse still reflect the step.
- Async rst asserted mid-operation returns everything to reset values immediately. Decoding resumes from UNLOCKED after release.

Decomposition:
- step_phase_pkg holds:
  - the 8-entry half-step pattern table;
  - index width constant (3);
  - FSM state enum {UNLOCKED, LOCKED};
  - pattern_to_index function returning {legal, idle, index}.
- Sub-module phase_filter: 2-FF synchronizer plus stability counter. Outputs the accepted pattern and a one-cycle "new_pattern" strobe.

Test Plan (FILTER_CYCLES=4, POS_W=16):
- Reset, drive 0001, then the forward sequence 0011,0010,...,1001,0001 each held 20 cycles -> locked after first pattern; 8 step_pulses, dir=1, position=8, period=20 and period_valid=1 from the 2nd step.
- From locked at index 0, drive the reverse sequence 1001,1000,1100 -> position -3 (0xFFFD), dir=0, three pulses.
- Full-step drive 0001->0010->0100 -> position +4, two pulses, fault=0.
- Glitch: change pattern for 2 cycles then revert -> no step_pulse, position unchanged. Step change latency measured = 7 edges.
- Illegal 0101, then jump 0001->0110 (d=3) -> fault=1, locked=0 each time, position unchanged. clr -> fault=0, position=0.
- Preload position 0x7FFF by stepping, one more forward step -> 0x8000. Assert rst mid-hold -> all outputs to reset values asynchronously.
